// File: rtl/ibexc_trace_pkg.sv
// Shared types for the RVFI trace recorder: record layout, FSM states, filter bits.
// Optional feature macro TRACE_CAP_EN appends the destination capability to each record.
package ibexc_trace_pkg;

    typedef struct packed {
        logic       valid;
        logic [1:0] top_cor;
        logic [1:0] base_cor;
        logic [3:0] exp;
        logic [8:0] top;
        logic [8:0] base;
        logic [5:0] cperms;
        logic [2:0] otype;
    } reg_cap_t;

    localparam int REG_CAP_W = $bits(reg_cap_t);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_e;

    localparam int FILT_ALL  = 0;
    localparam int FILT_TRAP = 1;
    localparam int FILT_MEM  = 2;
    localparam int FILT_RD   = 3;

    // Everything in a record except the truncated order, which is prepended by the top.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
        logic        trap;
        logic        intr;
        logic        mem_rd;
        logic        mem_wr;
`ifdef TRACE_CAP_EN
        reg_cap_t    wcap;
`endif
    } trace_rec_t;

    function automatic int rec_w(int order_w);
        return order_w + $bits(trace_rec_t);
    endfunction

endpackage

// File: rtl/ibexc_rvfi_trace_buf_if.sv
// Valid/ready drain port of the trace recorder; master is the recorder, slave the consumer.
interface ibexc_rvfi_trace_buf_if #(
    parameter int RecW = ibexc_trace_pkg::rec_w(16)
);
    logic            valid;
    logic            ready;
    logic [RecW-1:0] rec;

    modport master (output valid, output rec, input ready);
    modport slave  (input valid, input rec, output ready);
endinterface

// File: rtl/ibexc_trace_ram.sv
// Depth x RecW record store: one synchronous write port, one asynchronous read port.
module ibexc_trace_ram #(
    parameter int Depth = 64,
    parameter int RecW  = 153
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(Depth)-1:0] waddr,
    input  logic [RecW-1:0]          wdata,
    input  logic [$clog2(Depth)-1:0] raddr,
    output logic [RecW-1:0]          rdata
);
    logic [RecW-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/ibexc_rvfi_trace_buf.sv
// RVFI retirement trace recorder: ring (pre/post trigger) or drop-counting stream capture.
// Optional feature macro TRACE_CAP_EN adds rvfi_rd_wcap_i to every stored record.
module ibexc_rvfi_trace_buf
    import ibexc_trace_pkg::*;
#(
    parameter int  Depth    = 64,
    parameter int  PostTrig = 16,
    parameter int  OrderW   = 16,
    localparam int RecW     = rec_w(OrderW)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    arm_i,
    input  logic                    stop_i,
    input  logic                    mode_i,
    input  logic [3:0]              filt_i,
    input  logic                    trig_pc_en_i,
    input  logic [31:0]             trig_pc_i,
    input  logic                    trig_on_trap_i,
    input  logic                    rvfi_valid_i,
    input  logic [63:0]             rvfi_order_i,
    input  logic [31:0]             rvfi_pc_rdata_i,
    input  logic [31:0]             rvfi_insn_i,
    input  logic                    rvfi_trap_i,
    input  logic                    rvfi_intr_i,
    input  logic [4:0]              rvfi_rd_addr_i,
    input  logic [31:0]             rvfi_rd_wdata_i,
    input  logic [31:0]             rvfi_mem_addr_i,
    input  logic [3:0]              rvfi_mem_rmask_i,
    input  logic [3:0]              rvfi_mem_wmask_i,
    input  reg_cap_t                rvfi_rd_wcap_i,
    ibexc_rvfi_trace_buf_if.master  out,
    output logic [1:0]              state_o,
    output logic [$clog2(Depth):0]  level_o,
    output logic [15:0]             drop_cnt_o,
    output logic                    triggered_o
);
    localparam int PtrW = $clog2(Depth);
    localparam int LvlW = PtrW + 1;
    localparam logic [LvlW-1:0] FullLvl  = LvlW'(Depth);
    localparam logic [PtrW-1:0] PostInit = PtrW'(PostTrig);

    trace_state_e    state;
    logic            mode;
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [PtrW-1:0] post_cnt;
    logic [LvlW-1:0] level;
    logic [15:0]     drop_cnt;
    logic            triggered;

    logic            cap;
    logic            trig;
    logic            full;
    logic            rd_allowed;
    logic            out_valid;
    logic            pop;
    logic            wr_en;
    logic            drop;
    logic            grow;
    logic            overwrite;
    trace_rec_t      body;
    logic [RecW-1:0] wr_rec;
    logic [RecW-1:0] rd_rec;

    always_comb begin
        body          = '0;
        body.pc       = rvfi_pc_rdata_i;
        body.insn     = rvfi_insn_i;
        body.rd_addr  = rvfi_rd_addr_i;
        body.rd_wdata = rvfi_rd_wdata_i;
        body.mem_addr = rvfi_mem_addr_i;
        body.trap     = rvfi_trap_i;
        body.intr     = rvfi_intr_i;
        body.mem_rd   = |rvfi_mem_rmask_i;
        body.mem_wr   = |rvfi_mem_wmask_i;
`ifdef TRACE_CAP_EN
        body.wcap     = rvfi_rd_wcap_i;
`endif
    end

    assign wr_rec = {rvfi_order_i[OrderW-1:0], body};

`ifdef TRACE_CAP_EN
    logic unused_in;
    assign unused_in = ^(rvfi_order_i >> OrderW);
`else
    logic unused_in;
    assign unused_in = ^{rvfi_order_i >> OrderW, rvfi_rd_wcap_i};
`endif

    always_comb begin
        cap = rvfi_valid_i & (filt_i[FILT_ALL]
                            | (filt_i[FILT_TRAP] & (rvfi_trap_i | rvfi_intr_i))
                            | (filt_i[FILT_MEM] & (|{rvfi_mem_rmask_i, rvfi_mem_wmask_i}))
                            | (filt_i[FILT_RD] & (rvfi_rd_addr_i != 5'd0)));
        trig = rvfi_valid_i & ((trig_pc_en_i & (rvfi_pc_rdata_i == trig_pc_i))
                             | (trig_on_trap_i & rvfi_trap_i));
        full       = (level == FullLvl);
        rd_allowed = (state == ST_DONE) | ((state == ST_ARMED) & mode);
        out_valid  = rd_allowed & (level != '0);
        pop        = out_valid & out.ready & ~arm_i;
        wr_en      = 1'b0;
        drop       = 1'b0;
        if (!arm_i && !stop_i) begin
            case (state)
                ST_ARMED: begin
                    if (mode) begin
                        // A pop on the same edge frees the head slot the write lands in.
                        if (cap && (!full || pop)) wr_en = 1'b1;
                        else if (cap)               drop  = 1'b1;
                    end else begin
                        wr_en = cap | trig;
                    end
                end
                ST_POST: wr_en = cap;
                default: ;
            endcase
        end
        grow      = wr_en & (~full | pop);
        overwrite = wr_en & full & ~pop;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            mode      <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            post_cnt  <= '0;
            level     <= '0;
            drop_cnt  <= '0;
            triggered <= 1'b0;
        end else if (arm_i) begin
            state     <= ST_ARMED;
            mode      <= mode_i;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            post_cnt  <= '0;
            level     <= '0;
            drop_cnt  <= '0;
            triggered <= 1'b0;
        end else begin
            if (wr_en)            wr_ptr <= wr_ptr + 1'b1;
            if (pop || overwrite) rd_ptr <= rd_ptr + 1'b1;
            level <= level + LvlW'(grow) - LvlW'(pop);
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            case (state)
                ST_ARMED: begin
                    if (stop_i) begin
                        state <= ST_DONE;
                    end else if (!mode && trig) begin
                        triggered <= 1'b1;
                        if (PostTrig == 0) begin
                            state <= ST_DONE;
                        end else begin
                            state    <= ST_POST;
                            post_cnt <= PostInit;
                        end
                    end
                end
                ST_POST: begin
                    if (stop_i) begin
                        state <= ST_DONE;
                    end else if (cap) begin
                        post_cnt <= post_cnt - 1'b1;
                        if (post_cnt == PtrW'(1)) state <= ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    ibexc_trace_ram #(
        .Depth (Depth),
        .RecW  (RecW)
    ) u_ram (
        .clk   (clk_i),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (wr_rec),
        .raddr (rd_ptr),
        .rdata (rd_rec)
    );

    // Gating keeps the record port at zero whenever nothing is offered, including reset.
    assign out.valid   = out_valid;
    assign out.rec     = out_valid ? rd_rec : '0;
    assign state_o     = state;
    assign level_o     = level;
    assign drop_cnt_o  = drop_cnt;
    assign triggered_o = triggered;
endmodule

// File: tb/tb_ibexc_rvfi_trace_buf.sv
// Directed bench for ibexc_rvfi_trace_buf: ring/trigger, stream/drop, filters, back-pressure, reset.
module tb_ibexc_rvfi_trace_buf;
    import ibexc_trace_pkg::*;

    localparam int ORDER_W = 16;
    localparam int RECW    = rec_w(ORDER_W);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, arm_a, arm_b, stop_a, stop_b, mode;
    logic [3:0]  filt;
    logic        trig_pc_en, trig_on_trap;
    logic [31:0] trig_pc;
    logic        rvfi_valid, trap, intr;
    logic [63:0] rvfi_order;
    logic [31:0] pc, insn, rd_wdata, mem_addr;
    logic [4:0]  rd_addr;
    logic [3:0]  rmask, wmask;
    reg_cap_t    wcap;
    logic [1:0]  state_a, state_b;
    logic [6:0]  lvl_a;
    logic [2:0]  lvl_b;
    logic [15:0] drop_a, drop_b;
    logic        trg_a, trg_b;

    ibexc_rvfi_trace_buf_if #(.RecW(RECW)) ifa ();
    ibexc_rvfi_trace_buf_if #(.RecW(RECW)) ifb ();

    ibexc_rvfi_trace_buf #(.Depth(64), .PostTrig(16), .OrderW(ORDER_W)) dut_a (
        .clk_i(clk), .rst_i(rst), .arm_i(arm_a), .stop_i(stop_a), .mode_i(mode), .filt_i(filt),
        .trig_pc_en_i(trig_pc_en), .trig_pc_i(trig_pc), .trig_on_trap_i(trig_on_trap),
        .rvfi_valid_i(rvfi_valid), .rvfi_order_i(rvfi_order), .rvfi_pc_rdata_i(pc),
        .rvfi_insn_i(insn), .rvfi_trap_i(trap), .rvfi_intr_i(intr), .rvfi_rd_addr_i(rd_addr),
        .rvfi_rd_wdata_i(rd_wdata), .rvfi_mem_addr_i(mem_addr), .rvfi_mem_rmask_i(rmask),
        .rvfi_mem_wmask_i(wmask), .rvfi_rd_wcap_i(wcap), .out(ifa), .state_o(state_a),
        .level_o(lvl_a), .drop_cnt_o(drop_a), .triggered_o(trg_a));

    ibexc_rvfi_trace_buf #(.Depth(4), .PostTrig(0), .OrderW(ORDER_W)) dut_b (
        .clk_i(clk), .rst_i(rst), .arm_i(arm_b), .stop_i(stop_b), .mode_i(mode), .filt_i(filt),
        .trig_pc_en_i(trig_pc_en), .trig_pc_i(trig_pc), .trig_on_trap_i(trig_on_trap),
        .rvfi_valid_i(rvfi_valid), .rvfi_order_i(rvfi_order), .rvfi_pc_rdata_i(pc),
        .rvfi_insn_i(insn), .rvfi_trap_i(trap), .rvfi_intr_i(intr), .rvfi_rd_addr_i(rd_addr),
        .rvfi_rd_wdata_i(rd_wdata), .rvfi_mem_addr_i(mem_addr), .rvfi_mem_rmask_i(rmask),
        .rvfi_mem_wmask_i(wmask), .rvfi_rd_wcap_i(wcap), .out(ifb), .state_o(state_b),
        .level_o(lvl_b), .drop_cnt_o(drop_b), .triggered_o(trg_b));

    int n_vec = 0;
    int n_bad = 0;
    logic [RECW-1:0] exp_q[$];

    typedef struct {
        logic       vld;
        logic [3:0] filt;
        logic [4:0] rd;
        logic [3:0] rm;
        logic [3:0] wm;
        logic       tp;
        logic       it;
        int         lvl;
    } vec_t;
    vec_t tbl[16];

    function automatic logic [31:0] pc_of(int o);
        return 32'h2000_0100 + 32'(o - 100) * 32'd4;
    endfunction
    function automatic logic [31:0] insn_of(int o);
        return 32'h0000_0013 ^ (32'(o) << 7);
    endfunction
    function automatic logic [31:0] wdata_of(int o);
        return 32'hC0DE_0000 + 32'(o);
    endfunction
    function automatic logic [31:0] maddr_of(int o);
        return 32'h8000_0000 + 32'(o) * 32'd16;
    endfunction
    function automatic logic [3:0] rm_of(int o);
        return (o % 7 == 0) ? 4'hF : 4'h0;
    endfunction
    function automatic logic [3:0] wm_of(int o);
        return (o % 11 == 0) ? 4'h3 : 4'h0;
    endfunction
    function automatic logic [REG_CAP_W-1:0] wcap_of(int o);
        return REG_CAP_W'({wdata_of(o), ~wdata_of(o)});
    endfunction

    function automatic logic [RECW-1:0] exp_rec(int o, logic [4:0] rd, logic [3:0] rm,
                                                 logic [3:0] wm, logic tp, logic it);
`ifdef TRACE_CAP_EN
        return {16'(o), pc_of(o), insn_of(o), rd, wdata_of(o), maddr_of(o), tp, it, |rm, |wm,
                wcap_of(o)};
`else
        return {16'(o), pc_of(o), insn_of(o), rd, wdata_of(o), maddr_of(o), tp, it, |rm, |wm};
`endif
    endfunction
    function automatic logic [RECW-1:0] exp_std(int o);
        return exp_rec(o, 5'(o), rm_of(o), wm_of(o), 1'b0, 1'b0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_rec(string nm, logic [RECW-1:0] act, logic [RECW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic retire(int o, logic [4:0] rd, logic [3:0] rm, logic [3:0] wm,
                          logic tp, logic it);
        rvfi_valid = 1'b1;
        rvfi_order = 64'(o);
        pc         = pc_of(o);
        insn       = insn_of(o);
        rd_addr    = rd;
        rd_wdata   = wdata_of(o);
        mem_addr   = maddr_of(o);
        rmask      = rm;
        wmask      = wm;
        trap       = tp;
        intr       = it;
        wcap       = reg_cap_t'(wcap_of(o));
        tick();
        rvfi_valid = 1'b0;
    endtask

    task automatic retire_std(int o);
        retire(o, 5'(o), rm_of(o), wm_of(o), 1'b0, 1'b0);
    endtask

    task automatic drain_a(string nm);
        ifa.ready = 1'b1;
        while (exp_q.size() != 0) begin
            chk({nm, "_vld"}, 64'(ifa.valid), 64'd1);
            chk_rec(nm, ifa.rec, exp_q.pop_front());
            tick();
        end
        ifa.ready = 1'b0;
        chk({nm, "_empty"}, 64'(ifa.valid), 64'd0);
    endtask

    task automatic drain_b(string nm);
        ifb.ready = 1'b1;
        while (exp_q.size() != 0) begin
            chk({nm, "_vld"}, 64'(ifb.valid), 64'd1);
            chk_rec(nm, ifb.rec, exp_q.pop_front());
            tick();
        end
        ifb.ready = 1'b0;
        chk({nm, "_empty"}, 64'(ifb.valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic v, r;
        int   ord, drops, prev;
        logic [RECW-1:0] mq[$];

        // vld, filt, rd, rmask, wmask, trap, intr, expected level afterwards
        tbl[0]  = '{1'b1, 4'b0100, 5'd5,  4'h0, 4'h0, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b1, 4'b0100, 5'd6,  4'hF, 4'h0, 1'b0, 1'b0, 1};
        tbl[2]  = '{1'b1, 4'b0100, 5'd0,  4'h0, 4'hF, 1'b0, 1'b0, 2};
        tbl[3]  = '{1'b1, 4'b0100, 5'd7,  4'h0, 4'h0, 1'b0, 1'b0, 2};
        tbl[4]  = '{1'b1, 4'b0100, 5'd8,  4'h1, 4'h0, 1'b0, 1'b0, 3};
        tbl[5]  = '{1'b1, 4'b0100, 5'd0,  4'h0, 4'h3, 1'b0, 1'b0, 4};
        tbl[6]  = '{1'b1, 4'b0100, 5'd9,  4'h3, 4'h0, 1'b0, 1'b0, 5};
        tbl[7]  = '{1'b1, 4'b0100, 5'd10, 4'h0, 4'h0, 1'b0, 1'b0, 5};
        tbl[8]  = '{1'b1, 4'b1000, 5'd0,  4'hF, 4'h0, 1'b0, 1'b0, 5};
        tbl[9]  = '{1'b1, 4'b1000, 5'd3,  4'h0, 4'h0, 1'b0, 1'b0, 6};
        tbl[10] = '{1'b1, 4'b0010, 5'd4,  4'h0, 4'h0, 1'b1, 1'b0, 7};
        tbl[11] = '{1'b1, 4'b0010, 5'd4,  4'h0, 4'h0, 1'b0, 1'b1, 8};
        tbl[12] = '{1'b1, 4'b0010, 5'd4,  4'h0, 4'h0, 1'b0, 1'b0, 8};
        tbl[13] = '{1'b1, 4'b0000, 5'd4,  4'hF, 4'h0, 1'b0, 1'b0, 8};
        tbl[14] = '{1'b1, 4'b0001, 5'd0,  4'h0, 4'h0, 1'b0, 1'b0, 9};
        tbl[15] = '{1'b0, 4'b0001, 5'd1,  4'h0, 4'h0, 1'b0, 1'b0, 9};

        rst = 1'b1; arm_a = 1'b0; arm_b = 1'b0; stop_a = 1'b0; stop_b = 1'b0; mode = 1'b0;
        filt = 4'b0001; trig_pc_en = 1'b0; trig_pc = '0; trig_on_trap = 1'b0;
        rvfi_valid = 1'b0; rvfi_order = '0; pc = '0; insn = '0; trap = 1'b0; intr = 1'b0;
        rd_addr = '0; rd_wdata = '0; mem_addr = '0; rmask = '0; wmask = '0; wcap = '0;
        ifa.ready = 1'b0; ifb.ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        chk("rst_state_a", 64'(state_a), 64'(ST_IDLE));
        chk("rst_level_a", 64'(lvl_a), 64'd0);
        chk("rst_drop_a", 64'(drop_a), 64'd0);
        chk("rst_trig_a", 64'(trg_a), 64'd0);
        chk("rst_valid_a", 64'(ifa.valid), 64'd0);
        chk_rec("rst_rec_a", ifa.rec, '0);
        chk("rst_state_b", 64'(state_b), 64'(ST_IDLE));
        chk("rst_level_b", 64'(lvl_b), 64'd0);
        chk("rst_valid_b", 64'(ifb.valid), 64'd0);

        // Ring capture around a PC trigger at retirement 100
        mode = 1'b0; filt = 4'b0001; trig_pc_en = 1'b1; trig_pc = 32'h2000_0100;
        arm_a = 1'b1; tick(); arm_a = 1'b0;
        chk("t1_armed", 64'(state_a), 64'(ST_ARMED));
        for (int o = 0; o < 200; o++) begin
            retire_std(o);
            if (o == 63)  chk("t1_full_lvl", 64'(lvl_a), 64'd64);
            if (o == 70)  chk("t1_sat_lvl", 64'(lvl_a), 64'd64);
            if (o == 99)  chk("t1_pre_trig", 64'(state_a), 64'(ST_ARMED));
            if (o == 100) chk("t1_post", 64'(state_a), 64'(ST_POST));
            if (o == 100) chk("t1_triggered", 64'(trg_a), 64'd1);
            if (o == 115) chk("t1_still_post", 64'(state_a), 64'(ST_POST));
            if (o == 116) chk("t1_done", 64'(state_a), 64'(ST_DONE));
        end
        chk("t1_level", 64'(lvl_a), 64'd64);
        for (int o = 53; o <= 116; o++) exp_q.push_back(exp_std(o));
        drain_a("t1_drain");
        chk("t1_done_after_drain", 64'(state_a), 64'(ST_DONE));
        trig_pc_en = 1'b0;

        // Stream mode with no consumer, then a write and pop on the same edge while full
        mode = 1'b1; filt = 4'b0001;
        arm_b = 1'b1; tick(); arm_b = 1'b0;
        for (int o = 0; o < 10; o++) retire_std(o);
        chk("t2_level", 64'(lvl_b), 64'd4);
        chk("t2_drops", 64'(drop_b), 64'd6);
        chk("t2_state", 64'(state_b), 64'(ST_ARMED));
        ifb.ready = 1'b1;
        chk("t2_head_vld", 64'(ifb.valid), 64'd1);
        chk_rec("t2_head", ifb.rec, exp_std(0));
        retire_std(10);
        chk("t2_wp_level", 64'(lvl_b), 64'd4);
        chk("t2_wp_drops", 64'(drop_b), 64'd6);
        for (int o = 1; o <= 3; o++) exp_q.push_back(exp_std(o));
        exp_q.push_back(exp_std(10));
        drain_b("t2_drain");

        // Trap trigger with no post-trigger window
        mode = 1'b0; filt = 4'b0001; trig_on_trap = 1'b1;
        arm_b = 1'b1; tick(); arm_b = 1'b0;
        for (int o = 0; o < 7; o++) retire_std(o);
        chk("t4_armed", 64'(state_b), 64'(ST_ARMED));
        chk("t4_not_trig", 64'(trg_b), 64'd0);
        retire(7, 5'd7, rm_of(7), wm_of(7), 1'b1, 1'b0);
        chk("t4_done", 64'(state_b), 64'(ST_DONE));
        chk("t4_triggered", 64'(trg_b), 64'd1);
        retire_std(8);
        retire_std(9);
        chk("t4_frozen_lvl", 64'(lvl_b), 64'd4);
        for (int o = 4; o <= 6; o++) exp_q.push_back(exp_std(o));
        exp_q.push_back(exp_rec(7, 5'd7, rm_of(7), wm_of(7), 1'b1, 1'b0));
        drain_b("t4_drain");
        chk("t4_stays_done", 64'(state_b), 64'(ST_DONE));
        trig_on_trap = 1'b0;

        // Filter table
        mode = 1'b0;
        arm_a = 1'b1; tick(); arm_a = 1'b0;
        prev = 0;
        for (int i = 0; i < 16; i++) begin
            filt = tbl[i].filt;
            if (tbl[i].vld) retire(300 + i, tbl[i].rd, tbl[i].rm, tbl[i].wm, tbl[i].tp, tbl[i].it);
            else tick();
            chk($sformatf("filt_lvl[%0d]", i), 64'(lvl_a), 64'(tbl[i].lvl));
            if (tbl[i].lvl > prev)
                exp_q.push_back(exp_rec(300 + i, tbl[i].rd, tbl[i].rm, tbl[i].wm, tbl[i].tp, tbl[i].it));
            prev = tbl[i].lvl;
        end
        chk("t3_no_trig", 64'(trg_a), 64'd0);
        stop_a = 1'b1; tick(); stop_a = 1'b0;
        chk("t3_stop_done", 64'(state_a), 64'(ST_DONE));
        drain_a("t3_drain");

        // Random back-pressure against a stream-mode FIFO model
        mode = 1'b1; filt = 4'b0001;
        arm_b = 1'b1; tick(); arm_b = 1'b0;
        ord = 1000; drops = 0;
        for (int c = 0; c < 80; c++) begin
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            ifb.ready = r;
            chk("bp_vld", 64'(ifb.valid), 64'(mq.size() != 0));
            if (mq.size() != 0) chk_rec("bp_rec", ifb.rec, mq[0]);
            if (r && mq.size() != 0) void'(mq.pop_front());
            if (v) begin
                if (mq.size() < 4) mq.push_back(exp_std(ord));
                else drops++;
                retire_std(ord);
                ord++;
            end else begin
                tick();
            end
        end
        ifb.ready = 1'b0;
        chk("bp_drops", 64'(drop_b), 64'(drops));
        chk("bp_level", 64'(lvl_b), 64'(mq.size()));
        while (mq.size() != 0) exp_q.push_back(mq.pop_front());
        drain_b("bp_drain");

        // Reset while collecting post-trigger records, then re-arm from empty
        mode = 1'b0; filt = 4'b0001; trig_pc_en = 1'b1; trig_pc = pc_of(529);
        arm_a = 1'b1; tick(); arm_a = 1'b0;
        for (int o = 500; o < 530; o++) retire_std(o);
        chk("t6_post", 64'(state_a), 64'(ST_POST));
        chk("t6_level30", 64'(lvl_a), 64'd30);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_idle", 64'(state_a), 64'(ST_IDLE));
        chk("t6_level0", 64'(lvl_a), 64'd0);
        chk("t6_valid0", 64'(ifa.valid), 64'd0);
        chk("t6_trig0", 64'(trg_a), 64'd0);
        trig_pc_en = 1'b0;
        arm_a = 1'b1; tick(); arm_a = 1'b0;
        for (int o = 600; o < 603; o++) retire_std(o);
        chk("t6_rearm_lvl", 64'(lvl_a), 64'd3);
        stop_a = 1'b1; tick(); stop_a = 1'b0;
        for (int o = 600; o < 603; o++) exp_q.push_back(exp_std(o));
        drain_a("t6_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
